// File: rtl/cpu_test_pkg.sv
// Shared types and constants for the CPU run-control / self-check monitor.
// Holds the FSM state, the result codes and the layout of one register-check entry.
package cpu_test_pkg;

  localparam int MON_XLEN = 32;
  localparam logic [MON_XLEN-1:0] TOHOST_PASS = 32'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_TOHOST   = 2'd1,
    FC_TIMEOUT  = 2'd2,
    FC_MISMATCH = 2'd3
  } fail_code_t;

  typedef struct packed {
    logic                en;
    logic [4:0]          rd;
    logic [MON_XLEN-1:0] expected;
    logic [MON_XLEN-1:0] actual;
  } check_entry_t;

  // A timeout outranks a bad tohost value, which outranks register mismatches.
  function automatic fail_code_t resolve_fail(input logic timed_out,
                                              input logic tohost_ok,
                                              input logic any_mismatch);
    return timed_out     ? FC_TIMEOUT  :
           !tohost_ok    ? FC_TOHOST   :
           any_mismatch  ? FC_MISMATCH : FC_NONE;
  endfunction

endpackage

// File: rtl/mon_check_table.sv
// Register-check table: programmed expectations, shadowed writeback values,
// and one indexed compare port used by the scan.
module mon_check_table
  import cpu_test_pkg::*;
#(
  parameter int NUM_CHECKS = 8,
  parameter int IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic                cfg_en,
  input  logic [4:0]          cfg_rd,
  input  logic [MON_XLEN-1:0] cfg_val,
  input  logic                clr_actual,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic [MON_XLEN-1:0] wb_data,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic                mismatch
);

  check_entry_t entries [NUM_CHECKS];

  // NOTE: the table is a handful of flops, and a reset must wipe the whole
  // config, so every entry is reset rather than left as an unreset RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHECKS; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if (cfg_we && cfg_idx == IDX_W'(i)) begin
          entries[i].en       <= cfg_en;
          entries[i].rd       <= cfg_rd;
          entries[i].expected <= cfg_val;
        end
        // Duplicate entries on one register all shadow the same write; x0 never does.
        if (clr_actual) begin
          entries[i].actual <= '0;
        end else if (wb_valid && wb_rd != 5'd0 && entries[i].en && entries[i].rd == wb_rd) begin
          entries[i].actual <= wb_data;
        end
      end
    end
  end

  assign mismatch = entries[rd_idx].en && (entries[rd_idx].actual != entries[rd_idx].expected);

endmodule

// File: rtl/cpu_test_monitor.sv
// Run-control and self-check monitor: counts a run, ends it on a tohost store
// or timeout, then scans the check table one entry per cycle and reports.
module cpu_test_monitor
  import cpu_test_pkg::*;
#(
  parameter int              XLEN        = MON_XLEN,
  parameter int              NUM_CHECKS  = 8,
  parameter int              MAX_CYCLES  = 150,
  parameter int              CNT_W       = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_1000,
  localparam int             IDX_W       = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic                  cfg_en,
  input  logic [4:0]            cfg_rd,
  input  logic [XLEN-1:0]       cfg_val,
  input  logic                  retire_valid,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  mem_we,
  input  logic [XLEN-1:0]       mem_addr,
  input  logic [XLEN-1:0]       mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            fail_code,
  output logic [NUM_CHECKS-1:0] mismatch_mask,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      retire_count
);

  mon_state_t            state, state_next;
  fail_code_t            fail_q, verdict;
  logic [IDX_W-1:0]      scan_idx;
  logic [XLEN-1:0]       tohost_val;
  logic                  timed_out;
  logic                  row_mismatch;
  logic [NUM_CHECKS-1:0] mask_final;
  logic [CNT_W-1:0]      cycle_inc;

  wire run_start   = (state == IDLE) && start;
  wire in_run      = (state == RUN);
  wire tohost_hit  = in_run && mem_we && (mem_addr == TOHOST_ADDR);
  wire timeout_hit = in_run && (cycle_inc == CNT_W'(MAX_CYCLES));
  wire scan_last   = (state == CHECK) && (scan_idx == IDX_W'(NUM_CHECKS - 1));

  assign cycle_inc = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
  assign fail_code = fail_q;

  mon_check_table #(.NUM_CHECKS(NUM_CHECKS), .IDX_W(IDX_W)) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     ((state == IDLE) && cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_en     (cfg_en),
    .cfg_rd     (cfg_rd),
    .cfg_val    (cfg_val),
    .clr_actual (run_start),
    .wb_valid   (in_run && wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .rd_idx     (scan_idx),
    .mismatch   (row_mismatch)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: defaulting state_next first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)      state_next = RUN;
      RUN:     if (tohost_hit || timeout_hit) state_next = CHECK;
      CHECK:   if (scan_last)  state_next = DONE;
      DONE:    if (clear)      state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == CHECK);
    done = (state == DONE);
  end

  // The verdict must see the bit being scanned this cycle, not just the stored mask.
  always_comb begin
    mask_final           = mismatch_mask;
    mask_final[scan_idx] = row_mismatch;
    verdict = resolve_fail(timed_out, tohost_val == XLEN'(TOHOST_PASS), |mask_final);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= '0;
      retire_count  <= '0;
      scan_idx      <= '0;
      tohost_val    <= '0;
      timed_out     <= 1'b0;
      mismatch_mask <= '0;
      fail_q        <= FC_NONE;
      pass          <= 1'b0;
    end else if (run_start) begin
      cycle_count   <= '0;
      retire_count  <= '0;
      scan_idx      <= '0;
      tohost_val    <= '0;
      timed_out     <= 1'b0;
      mismatch_mask <= '0;
      fail_q        <= FC_NONE;
      pass          <= 1'b0;
    end else if (in_run) begin
      cycle_count <= cycle_inc;
      if (retire_valid && !(&retire_count)) retire_count <= retire_count + CNT_W'(1);
      if (tohost_hit)       tohost_val <= mem_wdata;
      else if (timeout_hit) timed_out  <= 1'b1;
    end else if (state == CHECK) begin
      mismatch_mask[scan_idx] <= row_mismatch;
      scan_idx                <= scan_idx + IDX_W'(1);
      if (scan_last) begin
        fail_q <= verdict;
        pass   <= (verdict == FC_NONE);
      end
    end
  end

endmodule

// File: tb/tb_cpu_test_monitor.sv
// Directed bench for cpu_test_monitor: a run-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_cpu_test_monitor;

  localparam int          NC     = 8;
  localparam int          MAXC   = 150;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, clear = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [4:0]  cfg_rd = '0, wb_rd = '0;
  logic [31:0] cfg_val = '0, wb_data = '0, mem_addr = '0, mem_wdata = '0;
  logic        retire_valid = 1'b0, wb_valid = 1'b0, mem_we = 1'b0;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [7:0]  mismatch_mask;
  logic [31:0] cycle_count, retire_count;

  cpu_test_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_rd(cfg_rd), .cfg_val(cfg_val),
    .retire_valid(retire_valid), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .mismatch_mask(mismatch_mask), .cycle_count(cycle_count), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Run-level model: a run is idle, running, waiting out the scan, or finished.
  int          m_mode = 0;   // 0 idle, 1 running, 2 scanning, 3 finished
  int          m_wait = 0;
  longint      m_cyc = 0, m_ret = 0;
  logic [7:0]  m_mask = '0;
  int          m_fc = 0;
  bit          m_pass = 1'b0;
  bit          m_en  [NC];
  logic [4:0]  m_rd  [NC];
  logic [31:0] m_exp [NC];
  logic [31:0] m_act [NC];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_wait = 0; m_cyc = 0; m_ret = 0; m_mask = '0; m_fc = 0; m_pass = 1'b0;
      for (int i = 0; i < NC; i++) begin
        m_en[i] = 1'b0; m_rd[i] = '0; m_exp[i] = '0; m_act[i] = '0;
      end
    end else begin
      case (m_mode)
        0: begin
          if (cfg_we) begin
            m_en[cfg_idx] = cfg_en; m_rd[cfg_idx] = cfg_rd; m_exp[cfg_idx] = cfg_val;
          end
          if (start) begin
            m_mode = 1; m_cyc = 0; m_ret = 0; m_mask = '0; m_fc = 0;
            for (int i = 0; i < NC; i++) m_act[i] = '0;
          end
        end
        1: begin
          bit th, to;
          m_cyc++;
          if (retire_valid) m_ret++;
          if (wb_valid && wb_rd != 0)
            for (int i = 0; i < NC; i++) if (m_en[i] && m_rd[i] == wb_rd) m_act[i] = wb_data;
          th = mem_we && mem_addr == TOHOST;
          to = (m_cyc == MAXC);
          if (th || to) begin
            for (int i = 0; i < NC; i++) m_mask[i] = m_en[i] && (m_act[i] != m_exp[i]);
            if (!th)                 m_fc = 2;
            else if (mem_wdata != 1) m_fc = 1;
            else if (m_mask != 0)    m_fc = 3;
            else                     m_fc = 0;
            m_pass = (m_fc == 0);
            m_wait = NC;
            m_mode = 2;
          end
        end
        2: begin
          m_wait--;
          if (m_wait == 0) m_mode = 3;
        end
        default: if (clear) m_mode = 0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("busy", busy, (m_mode == 1 || m_mode == 2));
      check("done", done, (m_mode == 3));
      check("cycle_count", cycle_count, m_cyc);
      check("retire_count", retire_count, m_ret);
      if (m_mode != 2) begin
        check("fail_code", fail_code, m_fc);
        check("mismatch_mask", mismatch_mask, m_mask);
      end
      if (m_mode == 3) check("pass", pass, m_pass);
    end
  end

  task automatic drop();
    start = 0; clear = 0; cfg_we = 0; retire_valid = 0; wb_valid = 0; mem_we = 0;
  endtask

  task automatic step();
    @(posedge clk); #1; drop();
  endtask

  task automatic cfg(input int idx, input bit en, input int rd, input int val);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_en = en; cfg_rd = 5'(rd); cfg_val = 32'(val); step();
  endtask

  task automatic pulse_start(); start = 1; step(); endtask
  task automatic pulse_clear(); clear = 1; step(); endtask

  task automatic wb(input int rd, input int data);
    wb_valid = 1; retire_valid = 1; wb_rd = 5'(rd); wb_data = 32'(data); step();
  endtask

  task automatic store(input int data);
    mem_we = 1; mem_addr = TOHOST; mem_wdata = 32'(data); step();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 400) begin step(); n++; end
    check("done_reached", done, 1);
  endtask

  // Fibonacci in x1/x2: after k iterations x2 holds fib(k+1).
  task automatic run_fib(input int iters);
    int a, b, t;
    a = 0; b = 1;
    repeat (iters) begin
      t = a + b; a = b; b = t;
      wb(1, a); wb(2, b);
    end
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_cycles", cycle_count, 0);

    cfg(0, 1, 2, 55);
    pulse_start(); run_fib(9); store(1); wait_done(n);
    check("fib55_pass", pass, 1);
    check("fib55_code", fail_code, 0);
    check("fib55_mask", mismatch_mask, 8'h00);
    check("fib55_retire", retire_count, 18);
    check("fib55_cycles", cycle_count, 19);

    pulse_clear(); pulse_start(); run_fib(8); store(1); wait_done(n);
    check("done_latency", n, NC);
    check("fib34_pass", pass, 0);
    check("fib34_code", fail_code, 3);
    check("fib34_mask", mismatch_mask, 8'h01);

    pulse_clear();
    cfg(0, 1, 5, 3); cfg(3, 1, 5, 3); cfg(1, 1, 0, 0);
    pulse_start();
    cfg(3, 1, 5, 9);
    wb(5, 3);
    start = 1; wb(0, 7);
    store(1); wait_done(n);
    check("dup_pass", pass, 1);
    check("dup_mask", mismatch_mask, 8'h00);

    pulse_clear(); pulse_start(); wait_done(n);
    check("timeout_code", fail_code, 2);
    check("timeout_cycles", cycle_count, 150);
    check("timeout_mask", mismatch_mask, 8'h09);

    for (int r = 0; r < 2; r++) begin
      pulse_clear();
      check("clear_done", done, 0);
      pulse_start();
      repeat (40) begin retire_valid = 1; step(); end
      store(1); wait_done(n);
      check("retire40_count", retire_count, 40);
      check("retire40_cycles", cycle_count, 41);
      check("retire40_code", fail_code, 3);
      check("retire40_mask", mismatch_mask, 8'h09);
    end

    pulse_clear(); pulse_start(); repeat (5) step();
    check("midrun_busy", busy, 1);
    rst_n = 0; #1;
    check("async_busy", busy, 0);
    check("async_cycles", cycle_count, 0);
    check("async_retire", retire_count, 0);
    check("async_code", fail_code, 0);
    step(); rst_n = 1; step();
    pulse_start(); store(1); wait_done(n);
    check("post_reset_pass", pass, 1);
    check("post_reset_mask", mismatch_mask, 8'h00);

    pulse_clear(); pulse_start(); store(7); wait_done(n);
    check("bad_tohost_code", fail_code, 1);
    check("bad_tohost_cycles", cycle_count, 1);

    pulse_clear(); pulse_start(); repeat (MAXC - 1) step(); store(1); wait_done(n);
    check("tie_code", fail_code, 0);
    check("tie_pass", pass, 1);
    check("tie_cycles", cycle_count, 150);

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
